// File: rtl/jtkunio_gfxrom.sv
// Graphics ROM responder: one-entry cache per layer slot (char/scroll/object)
// with misses arbitrated onto a single SDRAM read port, char > scr > obj.
module jtkunio_gfxrom #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h04000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h24000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] char_addr,
  output logic [31:0] char_data,
  output logic        char_ok,
  input  logic [16:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [31:0] data_read
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  localparam logic [1:0] SEL_CHAR = 2'd0;
  localparam logic [1:0] SEL_SCR  = 2'd1;
  localparam logic [1:0] SEL_OBJ  = 2'd2;

  state_t      state_reg, state_next;
  logic        req_reg, req_next;
  logic [21:0] addr_reg, addr_next;
  logic [1:0]  sel_reg, sel_next;
  logic [17:0] lat_reg, lat_next;

  logic [13:0] char_tag_reg;
  logic [31:0] char_dat_reg;
  logic        char_valid_reg;
  logic [16:0] scr_tag_reg;
  logic [31:0] scr_dat_reg;
  logic        scr_valid_reg;
  logic [17:0] obj_tag_reg;
  logic [31:0] obj_dat_reg;
  logic        obj_valid_reg;

  logic fill, clr_char, clr_scr, clr_obj;
  logic char_miss, scr_miss, obj_miss;

  // Hits follow the live address combinationally; a moved address misses at once.
  assign char_ok   = char_valid_reg && (char_addr == char_tag_reg);
  assign scr_ok    = scr_valid_reg  && (scr_addr  == scr_tag_reg);
  assign obj_ok    = obj_cs && obj_valid_reg && (obj_addr == obj_tag_reg);
  assign char_miss = !char_ok;
  assign scr_miss  = !scr_ok;
  assign obj_miss  = obj_cs && !obj_ok;

  assign char_data  = char_dat_reg;
  assign scr_data   = scr_dat_reg;
  assign obj_data   = obj_dat_reg;
  assign sdram_addr = addr_reg;
  assign sdram_req  = req_reg;

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    sel_next   = sel_reg;
    lat_next   = lat_reg;
    fill       = 1'b0;
    clr_char   = 1'b0;
    clr_scr    = 1'b0;
    clr_obj    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (char_miss) begin
          sel_next   = SEL_CHAR;
          lat_next   = {4'd0, char_addr};
          addr_next  = CHAR_OFFSET + {8'd0, char_addr};
          req_next   = 1'b1;
          clr_char   = 1'b1;
          state_next = WAIT_ACK;
        end else if (scr_miss) begin
          sel_next   = SEL_SCR;
          lat_next   = {1'b0, scr_addr};
          addr_next  = SCR_OFFSET + {5'd0, scr_addr};
          req_next   = 1'b1;
          clr_scr    = 1'b1;
          state_next = WAIT_ACK;
        end else if (obj_miss) begin
          sel_next   = SEL_OBJ;
          lat_next   = obj_addr;
          addr_next  = OBJ_OFFSET + {4'd0, obj_addr};
          req_next   = 1'b1;
          clr_obj    = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Data arriving with or ahead of the ack completes the fetch directly.
        if (data_rdy) begin
          fill       = 1'b1;
          req_next   = 1'b0;
          state_next = IDLE;
        end else if (sdram_ack) begin
          req_next   = 1'b0;
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_rdy) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_reg        <= 1'b0;
      addr_reg       <= 22'd0;
      sel_reg        <= SEL_CHAR;
      lat_reg        <= 18'd0;
      char_tag_reg   <= 14'd0;
      char_dat_reg   <= 32'd0;
      char_valid_reg <= 1'b0;
      scr_tag_reg    <= 17'd0;
      scr_dat_reg    <= 32'd0;
      scr_valid_reg  <= 1'b0;
      obj_tag_reg    <= 18'd0;
      obj_dat_reg    <= 32'd0;
      obj_valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      sel_reg   <= sel_next;
      lat_reg   <= lat_next;
      // Tags come from the latched address so a client that moved still misses.
      if (fill && sel_reg == SEL_CHAR) begin
        char_tag_reg   <= lat_reg[13:0];
        char_dat_reg   <= data_read;
        char_valid_reg <= 1'b1;
      end else if (clr_char) begin
        char_valid_reg <= 1'b0;
      end
      if (fill && sel_reg == SEL_SCR) begin
        scr_tag_reg   <= lat_reg[16:0];
        scr_dat_reg   <= data_read;
        scr_valid_reg <= 1'b1;
      end else if (clr_scr) begin
        scr_valid_reg <= 1'b0;
      end
      if (fill && sel_reg == SEL_OBJ) begin
        obj_tag_reg   <= lat_reg;
        obj_dat_reg   <= data_read;
        obj_valid_reg <= 1'b1;
      end else if (clr_obj) begin
        obj_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtkunio_gfxrom.sv
// Bench for jtkunio_gfxrom: directed scenarios plus randomized address traffic,
// checked against a per-slot "last filled address" model and a synthetic ROM.
module tb_jtkunio_gfxrom;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] char_addr;
  logic [31:0] char_data;
  logic        char_ok;
  logic [16:0] scr_addr;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs;
  logic [17:0] obj_addr;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;

  int passed = 0;
  int total  = 0;

  // Model: what each slot last received from memory and for which address.
  bit          mvalid [3];
  int          mtag   [3];
  logic [31:0] mdat   [3];

  jtkunio_gfxrom dut (
    .clk(clk), .rst(rst),
    .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [21:0] a);
    return {a[15:0] ^ 16'h5a3c, ~a[15:0]} ^ {10'h2b5, a};
  endfunction

  function automatic logic [21:0] off(input int s);
    case (s)
      0: return 22'h00000;
      1: return 22'h04000;
      default: return 22'h24000;
    endcase
  endfunction

  function automatic int caddr(input int s);
    case (s)
      0: return int'(char_addr);
      1: return int'(scr_addr);
      default: return int'(obj_addr);
    endcase
  endfunction

  function automatic int winner();
    if (!(mvalid[0] && int'(char_addr) == mtag[0])) return 0;
    if (!(mvalid[1] && int'(scr_addr) == mtag[1])) return 1;
    if (obj_cs && !(mvalid[2] && int'(obj_addr) == mtag[2])) return 2;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = 0;
      mdat[i]   = 32'd0;
    end
  endtask

  task automatic check_slots();
    chk("char_ok", char_ok, mvalid[0] && int'(char_addr) == mtag[0]);
    chk("scr_ok", scr_ok, mvalid[1] && int'(scr_addr) == mtag[1]);
    chk("obj_ok", obj_ok, obj_cs && mvalid[2] && int'(obj_addr) == mtag[2]);
    chk("char_data", char_data, mdat[0]);
    chk("scr_data", scr_data, mdat[1]);
    chk("obj_data", obj_data, mdat[2]);
  endtask

  // Act as the SDRAM controller for one fetch expected on slot s.
  task automatic serve(input int s, input int ca, input int ack_d, input int rdy_d, input bit chg);
    logic [21:0] ea;
    int k;
    int cnt;
    ea = off(s) + 22'(ca);
    k = 0;
    while (!sdram_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", sdram_req, 1);
    if (!sdram_req) return;
    chk("req_addr", sdram_addr, ea);
    mvalid[s] = 1'b0;
    check_slots();
    cnt = 1;
    repeat (ack_d) begin
      @(negedge clk);
      if (sdram_req) cnt++;
      chk("addr_hold", sdram_addr, ea);
    end
    sdram_ack = 1'b1;
    if (rdy_d == 0) begin
      data_rdy  = 1'b1;
      data_read = rom(ea);
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    chk("req_len", cnt, ack_d + 1);
    chk("req_drop", sdram_req, 0);
    if (rdy_d > 0) begin
      if (chg) obj_addr = obj_addr + 18'd1;
      repeat (rdy_d - 1) @(negedge clk);
      data_rdy  = 1'b1;
      data_read = rom(ea);
      @(negedge clk);
      data_rdy  = 1'b0;
      data_read = $urandom;
    end
    mvalid[s] = 1'b1;
    mtag[s]   = ca;
    mdat[s]   = rom(ea);
    $display("fetch slot=%0d addr=%06h ack_d=%0d rdy_d=%0d", s, ea, ack_d, rdy_d);
    check_slots();
  endtask

  task automatic expect_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("no_req", sdram_req, 0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) begin
      int w;
      w = winner();
      if (w < 0) break;
      serve(w, caddr(w), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    expect_idle(1);
    check_slots();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    char_addr = 14'h0010;
    scr_addr  = 17'h0;
    obj_cs    = 1'b0;
    obj_addr  = 18'h0;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    check_slots();

    // First char fetch: ack on the 2nd request cycle, data 5 cycles after req.
    rst = 1'b0;
    serve(0, 'h10, 1, 4, 1'b0);
    drain();

    // Address toggle drops ok immediately and refetches each time.
    char_addr = 14'h0011;
    #1 chk("toggle_ok", char_ok, 0);
    serve(0, 'h11, 0, 1, 1'b0);
    char_addr = 14'h0010;
    #1 chk("toggle_back_ok", char_ok, 0);
    serve(0, 'h10, 2, 1, 1'b0);
    expect_idle(1);

    // Simultaneous misses are served char, scr, obj.
    char_addr = 14'h0020;
    scr_addr  = 17'h00005;
    obj_cs    = 1'b1;
    obj_addr  = 18'h00003;
    #1 check_slots();
    serve(0, 'h20, 0, 1, 1'b0);
    serve(1, 5, 1, 2, 1'b0);
    serve(2, 3, 2, 0, 1'b0);
    expect_idle(2);

    // Object address moves during the fetch; fill lands with the stale tag.
    obj_addr = 18'h00007;
    serve(2, 7, 0, 2, 1'b1);
    serve(2, 8, 1, 1, 1'b0);
    obj_cs   = 1'b0;
    obj_addr = 18'h00009;
    #1 check_slots();
    expect_idle(4);
    check_slots();

    // Coincident ack and data.
    char_addr = 14'h0021;
    serve(0, 'h21, 0, 0, 1'b0);
    expect_idle(2);

    // Reset in WAIT_DATA, then a stray data_rdy in IDLE.
    char_addr = 14'h0030;
    k = 0;
    while (!sdram_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_test_req", sdram_req, 1);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", sdram_req, 0);
    model_reset();
    check_slots();
    rst       = 1'b0;
    data_rdy  = 1'b1;
    data_read = rom(22'h30);
    @(negedge clk);
    data_rdy = 1'b0;
    check_slots();
    chk("rst_new_req", sdram_req, 1);
    serve(0, 'h30, 1, 1, 1'b0);
    drain();

    // Random traffic over a small address range so hits and misses mix.
    for (int it = 0; it < 30; it++) begin
      char_addr = 14'($urandom_range(0, 3));
      scr_addr  = 17'($urandom_range(0, 3));
      obj_addr  = 18'($urandom_range(0, 3));
      obj_cs    = 1'($urandom_range(0, 1));
      #1 check_slots();
      drain();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
